// File: rtl/fir_filter_pipe.sv
// Pipelined signed direct-form FIR filter with run-time loadable coefficients,
// round-half-up output scaling, saturation and a sticky saturation flag.
module fir_filter_pipe #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 11,
  parameter int TAPS   = 9,
  parameter int FRAC   = 7,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   data_in,
  input  logic                       coef_wr,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  input  logic                       sat_clr,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   data_out,
  output logic                       sat_flag
);

  localparam int PW = DATA_W + COEF_W;
  localparam int GW = ACC_W + 1;
  localparam logic signed [GW-1:0] HALF    = GW'(1) << (FRAC - 1);
  localparam logic signed [GW-1:0] SAT_MAX = GW'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [GW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [COEF_W-1:0] coef_q [TAPS];
  logic signed [DATA_W-1:0] hist_q [TAPS-1];
  logic signed [PW-1:0]     prod_q [TAPS];
  logic signed [PW-1:0]     prod_d [TAPS];
  logic                     v1_q;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] data_out_q, data_out_d;
  logic                     sat_q, sat_d;

  logic signed [ACC_W-1:0]  acc_s;
  logic signed [GW-1:0]     rnd_s;
  logic signed [GW-1:0]     shr_s;
  logic signed [DATA_W-1:0] res_s;
  logic                     clip_s;

  // Products use the sample and history as they stand before the shift.
  always_comb begin
    prod_d[0] = PW'(data_in) * PW'(coef_q[0]);
    for (int k = 1; k < TAPS; k++) begin
      prod_d[k] = PW'(hist_q[k-1]) * PW'(coef_q[k]);
    end
  end

  // Sum, round half up, then clip; one guard bit keeps the rounding add exact.
  always_comb begin
    acc_s = '0;
    for (int k = 0; k < TAPS; k++) begin
      acc_s = acc_s + {{(ACC_W - PW){prod_q[k][PW-1]}}, prod_q[k]};
    end
    rnd_s = {acc_s[ACC_W-1], acc_s} + HALF;
    shr_s = rnd_s >>> FRAC;
    if (shr_s > SAT_MAX) begin
      clip_s = 1'b1;
      res_s  = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (shr_s < SAT_MIN) begin
      clip_s = 1'b1;
      res_s  = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      clip_s = 1'b0;
      res_s  = shr_s[DATA_W-1:0];
    end
  end

  // Output stage next state; a saturation in this cycle beats sat_clr.
  always_comb begin
    out_valid_d = v1_q;
    if (v1_q) begin
      data_out_d = res_s;
    end else begin
      data_out_d = data_out_q;
    end
    if (v1_q && clip_s) begin
      sat_d = 1'b1;
    end else if (sat_clr) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
  end

  // Sample history, stage-1 products and the stage-1 valid bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < TAPS - 1; k++) hist_q[k] <= '0;
      for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= in_valid;
      if (in_valid) begin
        for (int k = 0; k < TAPS; k++) prod_q[k] <= prod_d[k];
        hist_q[0] <= data_in;
        for (int k = 1; k < TAPS - 1; k++) hist_q[k] <= hist_q[k-1];
      end
    end
  end

  // Coefficient bank; reset leaves a unity pass-through on tap 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_q[0] <= COEF_W'(2 ** FRAC);
      for (int k = 1; k < TAPS; k++) coef_q[k] <= '0;
    end else if (coef_wr && (int'(coef_addr) < TAPS)) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      sat_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_fir_filter_pipe.sv
// Directed and randomized bench for fir_filter_pipe against an arithmetic
// reference model (convolution over an explicit sample history).
module tb_fir_filter_pipe;
  localparam int DATA_W = 16;
  localparam int COEF_W = 11;
  localparam int TAPS   = 9;
  localparam int FRAC   = 7;
  localparam int AW     = $clog2(TAPS);

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic signed [DATA_W-1:0] data_in;
  logic                     coef_wr;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     sat_clr;
  logic                     out_valid;
  logic signed [DATA_W-1:0] data_out;
  logic                     sat_flag;

  always #5 clk = ~clk;

  fir_filter_pipe #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
    .sat_clr(sat_clr), .out_valid(out_valid), .data_out(data_out), .sat_flag(sat_flag)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: past samples, coefficients, one result in flight.
  int hx[TAPS-1];
  int cb[TAPS];
  bit p_v;
  int p_y;
  bit p_clip;
  bit e_ov;
  int e_do;
  bit e_sat;
  int got[$];
  int exp_q[$];
  int tap2[TAPS] = '{0, 7, -3, -31, 68, -31, -3, 7, 0};

  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS - 1; k++) hx[k] = 0;
    cb[0] = 1 << FRAC;
    for (int k = 1; k < TAPS; k++) cb[k] = 0;
    p_v = 0; p_y = 0; p_clip = 0;
    e_ov = 0; e_do = 0; e_sat = 0;
  endtask

  task automatic step(input bit v, input int d, input bit wr, input int a,
                      input int c, input bit clr, input bit rst);
    longint acc;
    longint r;
    in_valid  = v;
    data_in   = d[DATA_W-1:0];
    coef_wr   = wr;
    coef_addr = a[AW-1:0];
    coef_data = c[COEF_W-1:0];
    sat_clr   = clr;
    reset     = rst;
    if (rst) begin
      model_reset();
    end else begin
      e_ov = p_v;
      if (p_v) e_do = p_y;
      if (p_v && p_clip) e_sat = 1;
      else if (clr) e_sat = 0;
      p_v = v;
      if (v) begin
        acc = longint'(cb[0]) * longint'(d);
        for (int k = 1; k < TAPS; k++) acc += longint'(cb[k]) * longint'(hx[k-1]);
        r = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
        p_clip = (r > 32767) || (r < -32768);
        p_y = (r > 32767) ? 32767 : (r < -32768) ? -32768 : int'(r);
        for (int k = TAPS - 2; k > 0; k--) hx[k] = hx[k-1];
        hx[0] = d;
      end
      if (wr && a < TAPS) cb[a] = c;
    end
    @(posedge clk);
    #1;
    chk("out_valid", {31'd0, out_valid}, int'(e_ov));
    chk("data_out", 32'(data_out), e_do);
    chk("sat_flag", {31'd0, sat_flag}, int'(e_sat));
    if (out_valid === 1'b1) got.push_back(int'(data_out));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_seq(input string tag);
    chk({tag, "_count"}, 32'(got.size()), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) chk(tag, got[i], exp_q[i]);
    got.delete();
  endtask

  initial begin
    in_valid = 0; data_in = '0; coef_wr = 0; coef_addr = '0;
    coef_data = '0; sat_clr = 0; reset = 1;
    model_reset();

    // Test 1: pass-through after reset
    step(0, 0, 0, 0, 0, 0, 1);
    chk("reset_out_valid", {31'd0, out_valid}, 0);
    chk("reset_data_out", 32'(data_out), 0);
    step(1, 100, 0, 0, 0, 0, 0);
    step(1, -5, 0, 0, 0, 0, 0);
    step(1, 32767, 0, 0, 0, 0, 0);
    idle(3);
    exp_q = '{100, -5, 32767};
    check_seq("t1_passthru");

    // Test 2: impulse response
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < TAPS; k++) step(0, 0, 1, k, tap2[k], 0, 0);
    step(1, 128, 0, 0, 0, 0, 0);
    for (int k = 1; k < TAPS; k++) step(1, 0, 0, 0, 0, 0, 0);
    idle(3);
    exp_q = '{0, 7, -3, -31, 68, -31, -3, 7, 0};
    check_seq("t2_impulse");

    // Test 3: rounding
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 0, 0);
    step(1, 64, 0, 0, 0, 0, 0);
    step(1, 63, 0, 0, 0, 0, 0);
    step(1, -64, 0, 0, 0, 0, 0);
    step(1, -65, 0, 0, 0, 0, 0);
    idle(3);
    exp_q = '{1, 0, 0, -1};
    check_seq("t3_round");

    // Test 4: saturation and sat_clr priority
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1023, 0, 0);
    step(1, 32767, 0, 0, 0, 0, 0);
    step(1, -32768, 0, 0, 0, 0, 0);
    chk("t4_sat_set", {31'd0, sat_flag}, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t4_sat_clr", {31'd0, sat_flag}, 0);
    step(1, 32767, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("t4_set_beats_clr", {31'd0, sat_flag}, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    exp_q = '{32767, -32768, 32767};
    check_seq("t4_sat");

    // Test 5: gapped impulse
    step(0, 0, 0, 0, 0, 0, 1);
    for (int k = 0; k < TAPS; k++) step(0, 0, 1, k, tap2[k], 0, 0);
    for (int k = 0; k < TAPS; k++) begin
      step(1, (k == 0) ? 128 : 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
    end
    idle(3);
    exp_q = '{0, 7, -3, -31, 68, -31, -3, 7, 0};
    check_seq("t5_gapped");

    // Test 6: write/sample collision, then reset mid-stream
    step(0, 0, 0, 0, 0, 0, 1);
    step(1, 10, 1, 0, 256, 0, 0);
    step(1, 10, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 7, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    step(1, 50, 0, 0, 0, 0, 0);
    idle(2);
    exp_q = '{10, 20, 50};
    check_seq("t6_collision_reset");

    // Out-of-range coefficient address is ignored
    step(0, 0, 1, 12, 300, 0, 0);
    step(1, 40, 0, 0, 0, 0, 0);
    idle(2);
    exp_q = '{40};
    check_seq("t6_bad_addr");

    // Randomized traffic: wide coefficients, then small ones
    for (int ph = 0; ph < 2; ph++) begin
      step(0, 0, 0, 0, 0, 0, 1);
      for (int k = 0; k < TAPS; k++)
        step(0, 0, 1, k, (ph == 0) ? int'($urandom_range(0, 2047)) - 1024
                                   : int'($urandom_range(0, 128)) - 64, 0, 0);
      for (int i = 0; i < 400; i++) begin
        step($urandom_range(0, 3) != 0,
             int'($urandom_range(0, 65535)) - 32768,
             $urandom_range(0, 9) == 0,
             int'($urandom_range(0, 15)),
             (ph == 0) ? int'($urandom_range(0, 2047)) - 1024 : int'($urandom_range(0, 128)) - 64,
             $urandom_range(0, 7) == 0,
             $urandom_range(0, 199) == 0);
      end
      got.delete();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
